seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
//  One shared SEG7DEC hex decoder serves every digit.
//  The block latches a packed hex word, walks the digit enables round-robin and inserts
//  a blanking gap per slot to suppress ghosting. It sits between user logic/switches
//  and the board HEX/AN pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_ctrl_seg7dec.sv | 42 ++++
 rtl/seg7_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the 7-segment scan controller.
//                Holds the scan FSM state type, the dark segment pattern and
//                the active-low hex-to-segment table ({g..a} bit order).
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_e;

  // All segments off (common-anode, active-low drive).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment codes {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] HEX_TO_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_ctrl_seg7dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7dec
//  Description : Combinational hex-to-7-segment decoder, active-low outputs.
//  Ports       : sw_i   [3:0] hex nibble to display
//                hex0_o [6:0] active-low segments {g..a}
//  Revision    : 1.0  initial release
// ============================================================================
module seg7dec (
  input  logic [3:0] sw_i,
  output logic [6:0] hex0_o
);

  logic [6:0] w_seg_on;  // active-high pattern, inverted at the output

  always_comb begin
    w_seg_on = 7'h00;
    case (sw_i)
      4'h0: w_seg_on = 7'h3F;
      4'h1: w_seg_on = 7'h06;
      4'h2: w_seg_on = 7'h5B;
      4'h3: w_seg_on = 7'h4F;
      4'h4: w_seg_on = 7'h66;
      4'h5: w_seg_on = 7'h6D;
      4'h6: w_seg_on = 7'h7D;
      4'h7: w_seg_on = 7'h07;
      4'h8: w_seg_on = 7'h7F;
      4'h9: w_seg_on = 7'h6F;
      4'hA: w_seg_on = 7'h77;
      4'hB: w_seg_on = 7'h7C;
      4'hC: w_seg_on = 7'h39;
      4'hD: w_seg_on = 7'h5E;
      4'hE: w_seg_on = 7'h79;
      4'hF: w_seg_on = 7'h71;
      default: w_seg_on = 7'h00;
    endcase
  end

  assign hex0_o = ~w_seg_on;

endmodule : seg7dec
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for a DIGITS-wide
//                common-anode 7-segment display. Each digit slot is TICK_DIV
//                cycles: GAP_CYC blanked cycles followed by the lit phase.
//                New data is staged in a pending register and committed to
//                the display register only at frame boundaries.
//  Ports       : clk_i         system clock (rising edge)
//                rst_i         synchronous active-high reset
//                enable_i      1 = scanning, 0 = display dark
//                load_i        strobe: capture data/dp/blank into pending
//                data_i        packed hex nibbles, digit 0 = rightmost
//                dp_in_i       decimal point per digit, 1 = lit
//                blank_mask_i  1 = digit never lit (slot still consumed)
//                seg_o         active-low segments {g..a}, registered
//                dp_o          active-low decimal point, registered
//                an_o          active-low digit enables, registered
//                frame_done_o  1-cycle pulse on each frame commit
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] data_i,
  input  logic [DIGITS-1:0]   dp_in_i,
  input  logic [DIGITS-1:0]   blank_mask_i,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [DIGITS-1:0]   an_o,
  output logic                frame_done_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // FSM and scan position
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;

  // Pending (written by load) and display (being scanned) registers
  logic [4*DIGITS-1:0] pend_data_q,  pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q,    pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*DIGITS-1:0] disp_data_q;
  logic [DIGITS-1:0]   disp_dp_q;
  logic [DIGITS-1:0]   disp_blank_q;

  // Output registers
  logic [6:0]          seg_q, seg_d;
  logic                dp_q,  dp_d;
  logic [DIGITS-1:0]   an_q,  an_d;
  logic                frame_done_q;

  logic [3:0]          w_nib;
  logic [6:0]          w_dec_seg;

  // A load in the same cycle as a commit must win, so the commit source is
  // the pending register's next value rather than its current one.
  always_comb begin
    pend_data_d  = load_i ? data_i       : pend_data_q;
    pend_dp_d    = load_i ? dp_in_i      : pend_dp_q;
    pend_blank_d = load_i ? blank_mask_i : pend_blank_q;
  end

  always_comb begin
    w_nib = disp_data_q[4*int'(idx_q) +: 4];
  end

  seg7dec u_seg7dec (
    .sw_i   (w_nib),
    .hex0_o (w_dec_seg)
  );

  // Output next values come from the current state/idx, so AN, SEG and DP
  // all appear together one cycle later. Dropping enable darkens the
  // display on the very next edge, regardless of state.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (enable_i && (state_q == SHOW)) begin
      seg_d = w_dec_seg;
      dp_d  = ~disp_dp_q[idx_q];
      if (!disp_blank_q[idx_q]) begin
        an_d[idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= 1'b0;

      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;

      if (!enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // Leaving IDLE starts a fresh frame with the latest pending data.
            state_q      <= GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_data_q  <= pend_data_d;
            disp_dp_q    <= pend_dp_d;
            disp_blank_q <= pend_blank_d;
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              state_q <= SHOW;
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
          SHOW: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= GAP;
              cnt_q   <= '0;
              if (idx_q == IDX_LAST) begin
                // Frame boundary: commit pending so a frame never mixes data.
                idx_q        <= '0;
                disp_data_q  <= pend_data_d;
                disp_dp_q    <= pend_dp_d;
                disp_blank_q <= pend_blank_d;
                frame_done_q <= 1'b1;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        endcase
      end
    end
  end

  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (DIGITS=4,
//                TICK_DIV=8, GAP_CYC=2). A frame-position model predicts the
//                registered outputs for every cycle; per-scenario tasks add
//                targeted checks on timing, tear-free update and blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 8;
  localparam int GAP_CYC  = 2;
  localparam int FRAME    = DIGITS * TICK_DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        fd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic        m_run;
  int          m_pos;
  logic [15:0] m_pend_data,  m_disp_data;
  logic [3:0]  m_pend_dp,    m_disp_dp;
  logic [3:0]  m_pend_blank, m_disp_blank;
  exp_t        sbq[$];

  seg7_scan_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .load_i       (load),
    .data_i       (data),
    .dp_in_i      (dp_in),
    .blank_mask_i (blank),
    .seg_o        (seg),
    .dp_o         (dp),
    .an_o         (an),
    .frame_done_o (fd)
  );

  always #5 clk = ~clk;

  // Predict the outputs after the coming edge from the current inputs,
  // advance one clock, then compare against the popped prediction.
  task automatic tick();
    exp_t e;
    exp_t got;
    int   slot;
    int   off;
    logic [3:0] nib;
    e = '{an: 4'hF, seg: SEG_OFF, dp: 1'b1, fd: 1'b0};
    if (rst) begin
      m_run = 1'b0; m_pos = 0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '1;
      m_disp_data = '0; m_disp_dp = '0; m_disp_blank = '1;
    end else if (!enable) begin
      m_run = 1'b0; m_pos = 0;
      if (load) begin m_pend_data = data; m_pend_dp = dp_in; m_pend_blank = blank; end
    end else if (!m_run) begin
      m_run = 1'b1; m_pos = 0;
      if (load) begin m_pend_data = data; m_pend_dp = dp_in; m_pend_blank = blank; end
      m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
    end else begin
      slot = m_pos / TICK_DIV;
      off  = m_pos % TICK_DIV;
      if (off >= GAP_CYC) begin
        nib   = m_disp_data[slot*4 +: 4];
        e.seg = HEX_TO_SEG[nib];
        e.dp  = ~m_disp_dp[slot];
        if (!m_disp_blank[slot]) e.an[slot] = 1'b0;
      end
      if (load) begin m_pend_data = data; m_pend_dp = dp_in; m_pend_blank = blank; end
      if (m_pos == FRAME - 1) begin
        e.fd  = 1'b1;
        m_pos = 0;
        m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
      end else begin
        m_pos = m_pos + 1;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    got = sbq.pop_front();
    total = total + 1;
    if ({an, seg, dp, fd} !== {got.an, got.seg, got.dp, got.fd}) begin
      bad = bad + 1;
      $display("FAIL sb_outputs cyc=%0d got an=%h seg=%h dp=%b fd=%b exp an=%h seg=%h dp=%b fd=%b",
               cyc, an, seg, dp, fd, got.an, got.seg, got.dp, got.fd);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load = 1'b1; data = d; dp_in = p; blank = b;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; enable = 1'b1; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total = total + 1;
      if ({an, seg, dp, fd} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        bad = bad + 1;
        $display("FAIL reset_dark got an=%h seg=%h dp=%b fd=%b exp an=f seg=7f dp=1 fd=0", an, seg, dp, fd);
      end
    end
    rst = 1'b0;
    do_load(16'h1234, 4'h0, 4'h0);
    n = 0;
    while (an === 4'hF && n < 20) begin
      tick();
      n = n + 1;
    end
    total = total + 1;
    if (n !== GAP_CYC + 1) begin
      bad = bad + 1;
      $display("FAIL first_lit_delay got=%0d exp=%0d", n, GAP_CYC + 1);
    end
    total = total + 1;
    if (an !== 4'hE) begin
      bad = bad + 1;
      $display("FAIL first_lit_digit got=%h exp=e", an);
    end
  endtask

  task automatic test_walk();
    logic [3:0] an_seq[$];
    logic [6:0] seg_seq[$];
    int         fd_cyc[$];
    logic [3:0] exp_an [4];
    logic [3:0] prev;
    int         lit;
    exp_an = '{4'hE, 4'hD, 4'hB, 4'h7};
    enable = 1'b0;
    tick();
    do_load(16'h1234, 4'h0, 4'h0);
    enable = 1'b1;
    prev = 4'hF;
    lit  = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (an !== 4'hF && an !== prev) begin
        an_seq.push_back(an);
        seg_seq.push_back(seg);
      end
      prev = an;
      if (fd === 1'b1) fd_cyc.push_back(cyc);
      if (fd_cyc.size() == 1 && an !== 4'hF) lit = lit + 1;
    end
    for (int i = 0; i < 4; i++) begin
      total = total + 1;
      if (an_seq.size() <= i) begin
        bad = bad + 1;
        $display("FAIL walk_order digit=%0d got=none exp an=%h", i, exp_an[i]);
      end else if ({an_seq[i], seg_seq[i]} !== {exp_an[i], HEX_TO_SEG[4 - i]}) begin
        bad = bad + 1;
        $display("FAIL walk_order digit=%0d got an=%h seg=%h exp an=%h seg=%h",
                 i, an_seq[i], seg_seq[i], exp_an[i], HEX_TO_SEG[4 - i]);
      end
    end
    total = total + 1;
    if (fd_cyc.size() < 2) begin
      bad = bad + 1;
      $display("FAIL frame_period got pulses=%0d exp>=2", fd_cyc.size());
    end else if (fd_cyc[1] - fd_cyc[0] !== FRAME) begin
      bad = bad + 1;
      $display("FAIL frame_period got=%0d exp=%0d", fd_cyc[1] - fd_cyc[0], FRAME);
    end
    total = total + 1;
    if (lit !== DIGITS * (TICK_DIV - GAP_CYC)) begin
      bad = bad + 1;
      $display("FAIL lit_per_frame got=%0d exp=%0d", lit, DIGITS * (TICK_DIV - GAP_CYC));
    end
  endtask

  task automatic test_tear_free();
    int n;
    n = 0;
    while (m_pos != TICK_DIV + 3 && n < 40) begin tick(); n = n + 1; end
    do_load(16'hABCD, 4'h0, 4'h0);
    n = 0;
    while (an !== 4'hB && n < 20) begin tick(); n = n + 1; end
    total = total + 1;
    if ({an, seg} !== {4'hB, HEX_TO_SEG[2]}) begin
      bad = bad + 1;
      $display("FAIL tear_free got an=%h seg=%h exp an=b seg=%h", an, seg, HEX_TO_SEG[2]);
    end
    n = 0;
    while (fd !== 1'b1 && n < 40) begin tick(); n = n + 1; end
    n = 0;
    while (an !== 4'hE && n < 20) begin tick(); n = n + 1; end
    total = total + 1;
    if ({an, seg} !== {4'hE, HEX_TO_SEG[4'hD]}) begin
      bad = bad + 1;
      $display("FAIL commit_after_frame got an=%h seg=%h exp an=e seg=%h", an, seg, HEX_TO_SEG[4'hD]);
    end
    n = 0;
    while (m_pos != FRAME - 1 && n < 40) begin tick(); n = n + 1; end
    do_load(16'h5678, 4'h0, 4'h0);
    n = 0;
    while (an !== 4'hE && n < 20) begin tick(); n = n + 1; end
    total = total + 1;
    if ({an, seg} !== {4'hE, HEX_TO_SEG[8]}) begin
      bad = bad + 1;
      $display("FAIL wrap_bypass got an=%h seg=%h exp an=e seg=%h", an, seg, HEX_TO_SEG[8]);
    end
  endtask

  task automatic test_mask_dp();
    int n, ghost, dp_wrong, dp_low, d_cnt, fds;
    do_load(16'h5678, 4'b0010, 4'b0101);
    n = 0;
    while (fd !== 1'b1 && n < 40) begin tick(); n = n + 1; end
    ghost = 0; dp_wrong = 0; dp_low = 0; d_cnt = 0; fds = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (an === 4'hE || an === 4'hB) ghost = ghost + 1;
      if (dp === 1'b0 && an !== 4'hD) dp_wrong = dp_wrong + 1;
      if (dp === 1'b0) dp_low = dp_low + 1;
      if (an === 4'hD) d_cnt = d_cnt + 1;
      if (fd === 1'b1) fds = fds + 1;
    end
    total = total + 1;
    if (ghost !== 0) begin
      bad = bad + 1;
      $display("FAIL blanked_digit_lit got=%0d exp=0", ghost);
    end
    total = total + 1;
    if (dp_wrong !== 0) begin
      bad = bad + 1;
      $display("FAIL dp_wrong_digit got=%0d exp=0", dp_wrong);
    end
    total = total + 1;
    if ({dp_low, d_cnt} !== {32'd12, 32'd12}) begin
      bad = bad + 1;
      $display("FAIL dp_and_digit1_cycles got dp=%0d an_d=%0d exp 12 12", dp_low, d_cnt);
    end
    total = total + 1;
    if (fds !== 2) begin
      bad = bad + 1;
      $display("FAIL masked_frame_timing got=%0d exp=2", fds);
    end
  endtask

  task automatic test_enable_drop();
    int n, fds;
    n = 0;
    while (m_pos != 2 * TICK_DIV + 4 && n < 40) begin tick(); n = n + 1; end
    enable = 1'b0;
    tick();
    total = total + 1;
    if ({an, seg} !== {4'hF, 7'h7F}) begin
      bad = bad + 1;
      $display("FAIL drop_dark got an=%h seg=%h exp an=f seg=7f", an, seg);
    end
    do_load(16'h1234, 4'h0, 4'h0);
    fds = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fd === 1'b1 || an !== 4'hF) fds = fds + 1;
    end
    total = total + 1;
    if (fds !== 0) begin
      bad = bad + 1;
      $display("FAIL idle_activity got=%0d exp=0", fds);
    end
    enable = 1'b1;
    tick();
    n = 0;
    while (an === 4'hF && n < 20) begin tick(); n = n + 1; end
    total = total + 1;
    if ({n, an} !== {GAP_CYC + 1, 4'hE}) begin
      bad = bad + 1;
      $display("FAIL restart got delay=%0d an=%h exp delay=%0d an=e", n, an, GAP_CYC + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int lit, fds;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    total = total + 1;
    if ({an, seg, dp, fd} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad = bad + 1;
      $display("FAIL midframe_reset got an=%h seg=%h dp=%b fd=%b exp an=f seg=7f dp=1 fd=0", an, seg, dp, fd);
    end
    rst = 1'b0;
    lit = 0; fds = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an !== 4'hF) lit = lit + 1;
      if (fd === 1'b1) fds = fds + 1;
    end
    total = total + 1;
    if (lit !== 0) begin
      bad = bad + 1;
      $display("FAIL dark_after_reset got lit=%0d exp=0", lit);
    end
    total = total + 1;
    if (fds !== 1) begin
      bad = bad + 1;
      $display("FAIL fd_after_reset got=%0d exp=1", fds);
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_tear_free();
    test_mask_dp();
    test_enable_drop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
